// File: rtl/expr_eval_if.sv
// Character-stream and result bundle for expr_eval.
// The master side feeds characters; the slave side (the evaluator) reports status and value.
interface expr_eval_if #(
  parameter int WIDTH = 16
) ();
  logic             restart;
  logic             in_valid;
  logic [7:0]       in;
  logic             ok;
  logic             err;
  logic [WIDTH-1:0] value;

  modport master (output restart, in_valid, in, input ok, err, value);
  modport slave  (input restart, in_valid, in, output ok, err, value);
endinterface

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit expressions D(opD)* with '*' binding tighter than '+'.
// WIDTH must match the WIDTH of the connected expr_eval_if instance.
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);

  localparam logic [1:0] S_DIG = 2'd0;
  localparam logic [1:0] S_OP  = 2'd1;
  localparam logic [1:0] S_ERR = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             mul_pend_q, mul_pend_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] value_q, value_d;

  logic             is_digit, is_plus, is_star;
  logic [WIDTH-1:0] digit_w;

  // ASCII '0'..'9' are 8'h30..8'h39, so the low nibble is already the digit value.
  assign is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign is_plus  = (bus.in == 8'h2B);
  assign is_star  = (bus.in == 8'h2A);
  assign digit_w  = WIDTH'(bus.in[3:0]);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    term_d     = term_q;
    mul_pend_d = mul_pend_q;

    if (bus.restart) begin
      state_d    = S_DIG;
      sum_d      = '0;
      term_d     = '0;
      mul_pend_d = 1'b0;
    end else if (bus.in_valid) begin
      case (state_q)
        S_DIG: begin
          if (is_digit) begin
            term_d     = mul_pend_q ? WIDTH'(term_q * digit_w) : digit_w;
            mul_pend_d = 1'b0;
            state_d    = S_OP;
          end else begin
            state_d = S_ERR;
          end
        end
        S_OP: begin
          if (is_plus) begin
            sum_d      = sum_q + term_q;
            mul_pend_d = 1'b0;
            state_d    = S_DIG;
          end else if (is_star) begin
            mul_pend_d = 1'b1;
            state_d    = S_DIG;
          end else begin
            state_d = S_ERR;
          end
        end
        default: state_d = S_ERR;
      endcase
    end

    ok_d    = (state_d == S_OP);
    err_d   = (state_d == S_ERR);
    value_d = ok_d ? WIDTH'(sum_d + term_d) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= S_DIG;
      sum_q      <= '0;
      term_q     <= '0;
      mul_pend_q <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      value_q    <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      term_q     <= term_d;
      mul_pend_q <= mul_pend_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      value_q    <= value_d;
    end
  end

  assign bus.ok    = ok_q;
  assign bus.err   = err_q;
  assign bus.value = value_q;

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: a 16-bit and an 8-bit instance driven with identical character streams.
module tb_expr_eval;

  logic clk;
  logic clr;

  int checks = 0;
  int errors = 0;

  expr_eval_if #(.WIDTH(16)) bus16 ();
  expr_eval_if #(.WIDTH(8))  bus8  ();

  expr_eval #(.WIDTH(16)) dut16 (.clk(clk), .clr(clr), .bus(bus16.slave));
  expr_eval #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Compares the outputs of both instances; v8 is the expected value modulo 256.
  task automatic check_out(input string tag, input logic ok, input logic err,
                           input logic [31:0] v16, input logic [31:0] v8);
    check({tag, " ok16"},  32'(bus16.ok),    32'(ok));
    check({tag, " err16"}, 32'(bus16.err),   32'(err));
    check({tag, " val16"}, 32'(bus16.value), v16);
    check({tag, " ok8"},   32'(bus8.ok),     32'(ok));
    check({tag, " err8"},  32'(bus8.err),    32'(err));
    check({tag, " val8"},  32'(bus8.value),  v8);
  endtask

  task automatic drive(input logic rs, input logic vld, input logic [7:0] c);
    bus16.restart = rs;  bus16.in_valid = vld;  bus16.in = c;
    bus8.restart  = rs;  bus8.in_valid  = vld;  bus8.in  = c;
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic rs, input logic vld, input logic [7:0] c);
    drive(rs, vld, c);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic put(input logic [7:0] c);
    step(1'b0, 1'b1, c);
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic restart();
    step(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    clr = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    #12;
    check_out("reset", 1'b0, 1'b0, 0, 0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check_out("idle", 1'b0, 1'b0, 0, 0);

    // 1+2*3 with precedence
    put("1");  check_out("1",      1'b1, 1'b0, 1, 1);
    put("+");  check_out("1+",     1'b0, 1'b0, 0, 0);
    put("2");  check_out("1+2",    1'b1, 1'b0, 3, 3);
    put("*");  check_out("1+2*",   1'b0, 1'b0, 0, 0);
    put("3");  check_out("1+2*3",  1'b1, 1'b0, 7, 7);
    put("3");  check_out("digit after digit", 1'b0, 1'b1, 0, 0);
    put("+");  check_out("err sticky", 1'b0, 1'b1, 0, 0);

    // restart wins over a character in the same cycle
    step(1'b1, 1'b1, "1");
    check_out("restart discards", 1'b0, 1'b0, 0, 0);
    put_str("1+2");
    check_out("after restart 1+2", 1'b1, 1'b0, 3, 3);

    // wrap-around: 6561 fits 16 bits, 6561 mod 256 = 161
    restart();
    put_str("9*9*9*9");
    check_out("9*9*9*9", 1'b1, 1'b0, 6561, 161);

    // illegal character
    restart();
    put("4");  check_out("4",      1'b1, 1'b0, 4, 4);
    put("a");  check_out("4a",     1'b0, 1'b1, 0, 0);
    put("5");  check_out("4a5",    1'b0, 1'b1, 0, 0);

    // operator first is an illegal sequence
    restart();
    put("*");  check_out("leading op", 1'b0, 1'b1, 0, 0);

    // idle gap holds state
    restart();
    put_str("2*");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, "9");
      check_out("gap hold", 1'b0, 1'b0, 0, 0);
    end
    put("8");  check_out("2*8",    1'b1, 1'b0, 16, 16);

    // 3+4*5*6 = 123, larger mixed expression
    restart();
    put_str("3+4*5*6");
    check_out("3+4*5*6", 1'b1, 1'b0, 123, 123);
    // 123 + 9*9*9 = 852 ; 852 mod 256 = 84
    put_str("+9*9*9");
    check_out("+9*9*9", 1'b1, 1'b0, 852, 84);

    // asynchronous clear between edges
    restart();
    put_str("7+5");
    check_out("7+5", 1'b1, 1'b0, 12, 12);
    #2;
    clr = 1'b0;
    #1;
    check_out("async clr", 1'b0, 1'b0, 0, 0);
    #3;
    clr = 1'b1;
    @(posedge clk);
    #1;
    put("3");  check_out("after clr 3", 1'b1, 1'b0, 3, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Consumes the same per-cycle ASCII character stream as the string-format checker.
- Evaluates single-digit expressions of the form D(opD)*, where op is '+' or '*' and '*' binds tighter than '+'.
- Keeps a running result, a "well-formed so far" flag and a sticky error flag, so a downstream display or compare stage can read the value of the expression typed so far.

Parameters:
- WIDTH, 16, width of the accumulators and of the result; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-low reset. clr=0 immediately forces the reset state.
- restart  input  1  synchronous clear: begin a new expression at the next edge.
- in_valid  input  1  in holds a character to consume this cycle.
- in  input  8  ASCII character.
- ok  output  1  the expression accepted so far is well-formed and complete (ends in a digit).
- err  output  1  sticky: an illegal character or illegal sequence has been seen since the last restart/reset.
- value  output  WIDTH  evaluated result of the expression so far; valid while ok=1, otherwise 0.

Behaviour:
- States:
  - S_DIG: expecting a digit.
  - S_OP: expecting an operator; expression complete.
  - S_ERR: absorbing; left only by restart or clr.
- Registers:
  - sum[WIDTH-1:0]: committed additive part.
  - term[WIDTH-1:0]: current product term.
  - mul_pend: the last operator was '*'.
- Reset (clr=0, asynchronous): state=S_DIG, sum=0, term=0, mul_pend=0, ok=0, err=0, value=0.
- restart=1 at an edge: same effect as reset, applied synchronously.
  - restart has priority over in_valid; a character presented in the same cycle is discarded.
- in_valid=0: all state and outputs hold.
- Character classes: digit is '0'..'9' (d = in-8'h30); op is '+' or '*'; anything else is illegal.
- S_DIG + digit:
  - term <= mul_pend ? term*d : d (truncated to WIDTH).
  - mul_pend <= 0; go to S_OP.
- S_OP + '+': sum <= sum+term; mul_pend <= 0; go to S_DIG.
- S_OP + '*': mul_pend <= 1; go to S_DIG.
- S_DIG + op, S_OP + digit, or any state + illegal char: go to S_ERR.
- Outputs are registered and updated at the same edge as the state, so latency is one clock from the sampling edge.
  - ok = (next state == S_OP).
  - err = (next state == S_ERR).
  - value = ok ? sum_next + term_next : 0, computed modulo 2^WIDTH.
- An expression ending in an operator gives ok=0 and err=0 (incomplete, not an error).
- Wrap-around: products and sums silently truncate to WIDTH bits. There is no overflow flag.
- clr asserted mid-expression: outputs clear immediately, without waiting for a clock edge.
- Arithmetic is one multiply by a 4-bit constant (≤9) plus one adder per cycle; no multicycle paths.

Test Plan:
- "1","+","2","*","3" on consecutive cycles with in_valid=1:
  - after "1": ok=1, value=1.
  - after "+": ok=0, value=0, err=0.
  - after "3": ok=1, value=7.
- "1+2*3" then "3":
  - err=1, ok=0, value=0.
  - "+" afterwards: err stays 1.
  - restart=1 with in="1" in the same cycle: that "1" is discarded, outputs become 0; then "1","+","2" gives value=3.
- WIDTH=8, "9*9*9*9": value=161 (6561 mod 256), ok=1.
- "4","a": err=1 one cycle after "a" is sampled; "5" afterwards leaves err=1 and value=0.
- "2","*" then in_valid=0 for 3 cycles, then "8":
  - outputs hold ok=0 during the gap.
  - after "8": value=16.
- "7","+","5" then clr=0 asserted between edges:
  - ok, err and value go to 0 immediately.
  - after clr releases, "3" gives value=3.
